// File: rtl/alu_exec_stage.sv
// ALU operand-fetch / write-back stage: owns the 8x8 register file
// and flags; feeds the external combinational ALU and commits its result.
module alu_exec_stage #(
  parameter int NREGS = 8,
  parameter int RA_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      issue_op,
  input  logic [RA_W-1:0] issue_rd,
  input  logic [RA_W-1:0] issue_ra,
  input  logic [RA_W-1:0] issue_rb,
  input  logic            issue_use_imm,
  input  logic [7:0]      issue_imm,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [3:0]      alu_op,
  input  logic [7:0]      alu_out,
  input  logic            alu_zero,
  input  logic            alu_negative,
  input  logic            alu_carry,
  input  logic            alu_overflow,
  input  logic            alu_parity,
  output logic [4:0]      flags,
  output logic            done,
  input  logic [RA_W-1:0] dbg_addr,
  output logic [7:0]      dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [RA_W-1:0] ra_q, ra_d;
  logic [RA_W-1:0] rb_q, rb_d;
  logic            use_imm_q, use_imm_d;
  logic [7:0]      imm_q, imm_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [7:0]      res_q, res_d;
  logic [4:0]      pflags_q, pflags_d;
  logic [4:0]      flags_q, flags_d;
  logic [7:0]      regs_q [NREGS];
  logic [7:0]      regs_d [NREGS];

  logic [7:0] ra_val;
  logic [7:0] rb_val;

  assign ra_val = (ra_q == '0) ? 8'h00 : regs_q[ra_q];
  assign rb_val = (rb_q == '0) ? 8'h00 : regs_q[rb_q];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    res_d     = res_q;
    pflags_d  = pflags_q;
    flags_d   = flags_q;
    regs_d    = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          op_d      = issue_op;
          rd_d      = issue_rd;
          ra_d      = issue_ra;
          rb_d      = issue_rb;
          use_imm_d = issue_use_imm;
          imm_d     = issue_imm;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        alu_a_d  = ra_val;
        alu_b_d  = use_imm_q ? imm_q : rb_val;
        alu_op_d = op_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        res_d    = alu_out;
        pflags_d = {alu_zero, alu_negative,
                    alu_carry, alu_overflow,
                    alu_parity};
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        // r0 stays zero; flags commit anyway
        if (rd_q != '0) regs_d[rd_q] = res_q;
        flags_d = pflags_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      res_q     <= '0;
      pflags_q  <= '0;
      flags_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      res_q     <= res_d;
      pflags_q  <= pflags_d;
      flags_q   <= flags_d;
      regs_q    <= regs_d;
    end
  end

  assign issue_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_WRITE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign flags       = flags_q;
  assign dbg_data    = (dbg_addr == '0) ?
                       8'h00 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU on the DUT's ALU port,
// directed vector table, corner sequences, and random instructions.
module tb_alu_exec_stage;

  localparam logic [3:0] OP_SUM = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_LSL = 4'h6;
  localparam logic [3:0] OP_LSR = 4'h7;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_op;
  logic [2:0] issue_rd, issue_ra, issue_rb;
  logic       issue_use_imm;
  logic [7:0] issue_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_zero, alu_negative, alu_carry;
  logic       alu_overflow, alu_parity;
  logic [4:0] flags;
  logic       done;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  alu_exec_stage #(.NREGS(8), .RA_W(3)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_ra(issue_ra), .issue_rb(issue_rb),
    .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_parity(alu_parity),
    .flags(flags), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // returns {out[7:0], Z, N, C, V, P}
  function automatic logic [12:0] alu_f(input logic [3:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    int s;
    int amt;
    logic [7:0] o, nb;
    logic c, v;
    o = 8'h00; c = 1'b0; v = 1'b0;
    nb = ~b;
    amt = int'(b[2:0]);
    case (op)
      OP_SUM: begin
        s = int'(a) + int'(b);
        o = s[7:0];
        c = (s > 255);
        v = (a[7] == b[7]) && (o[7] != a[7]);
      end
      OP_SUB: begin
        s = int'(a) + int'(nb) + 1;
        o = s[7:0];
        c = (s > 255);
        v = (a[7] != b[7]) && (o[7] != a[7]);
      end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_XOR: o = a ^ b;
      OP_NOT: o = ~a;
      OP_LSL: begin
        o = a << amt;
        c = (amt == 0) ? 1'b0 : a[8-amt];
      end
      OP_LSR: begin
        o = a >> amt;
        c = (amt == 0) ? 1'b0 : a[amt-1];
      end
      default: o = 8'h00;
    endcase
    return {o, (o == 8'h00), o[7], c, v, ^o};
  endfunction

  always_comb begin
    {alu_out, alu_zero, alu_negative, alu_carry,
     alu_overflow, alu_parity} = alu_f(alu_op, alu_a, alu_b);
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_regs [8];
  logic [4:0] m_flags;

  function automatic logic [7:0] m_read(input logic [2:0] a);
    return (a == 3'd0) ? 8'h00 : m_regs[a];
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic do_issue(input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb,
                          input logic ui, input logic [7:0] imm);
    int waitc;
    logic [7:0] ea, eb, eo, got;
    logic [4:0] ef;
    waitc = 0;
    @(negedge clk);
    while (!issue_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_issue", issue_ready, 1);
    issue_op = op; issue_rd = rd; issue_ra = ra; issue_rb = rb;
    issue_use_imm = ui; issue_imm = imm;
    issue_valid = 1'b1;
    ea = m_read(ra);
    eb = ui ? imm : m_read(rb);
    {eo, ef} = alu_f(op, ea, eb);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    // later input changes must not matter
    issue_op = 4'($urandom); issue_rd = 3'($urandom);
    issue_ra = 3'($urandom); issue_rb = 3'($urandom);
    issue_use_imm = 1'($urandom); issue_imm = 8'($urandom);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("done_cycle%0d", k), done, (k == 3));
      check($sformatf("ready_cycle%0d", k), issue_ready, 0);
      check($sformatf("flags_hold_cycle%0d", k), flags, m_flags);
      if (k == 2) begin
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_op", alu_op, op);
      end
    end
    if (rd != 3'd0) m_regs[rd] = eo;
    m_flags = ef;
    @(negedge clk);
    check("done_cycle4", done, 0);
    check("ready_cycle4", issue_ready, 1);
    check("flags_commit", flags, m_flags);
    read_reg(rd, got);
    check($sformatf("reg_r%0d", rd), got, m_read(rd));
  endtask

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, ra, rb;
    logic       ui;
    logic [7:0] imm;
    logic [7:0] exp_val;
    logic [4:0] exp_flags;
  } vec_t;

  vec_t vecs [6];
  vec_t b2b [3];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] got;
    int dcount;
    int acc [3];
    int idx;
    int budget;
    logic rdy;

    vecs[0] = '{OP_SUM, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 8'h7F, 5'b00001};
    vecs[1] = '{OP_SUM, 3'd1, 3'd1, 3'd0, 1'b1, 8'h01, 8'h80, 5'b01011};
    vecs[2] = '{OP_SUM, 3'd2, 3'd0, 3'd0, 1'b1, 8'hFF, 8'hFF, 5'b01000};
    vecs[3] = '{OP_SUM, 3'd3, 3'd0, 3'd0, 1'b1, 8'h01, 8'h01, 5'b00001};
    vecs[4] = '{OP_SUM, 3'd4, 3'd2, 3'd3, 1'b0, 8'hAA, 8'h00, 5'b10100};
    vecs[5] = '{OP_SUB, 3'd0, 3'd0, 3'd0, 1'b1, 8'h01, 8'h00, 5'b01000};

    b2b[0] = '{OP_SUM, 3'd5, 3'd0, 3'd0, 1'b1, 8'h0F, 8'h00, 5'b0};
    b2b[1] = '{OP_LSL, 3'd5, 3'd5, 3'd0, 1'b1, 8'h04, 8'h00, 5'b0};
    b2b[2] = '{OP_NOT, 3'd6, 3'd5, 3'd0, 1'b1, 8'h00, 8'h00, 5'b0};

    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_flags = 5'b0;
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_op = 4'hF; issue_rd = 3'd7; issue_ra = 3'd7;
    issue_rb = 3'd7; issue_use_imm = 1'b1; issue_imm = 8'hA5;
    dbg_addr = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_ready", issue_ready, 1);
    check("reset_done", done, 0);
    check("reset_flags", flags, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_alu_op", alu_op, 0);
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), got);
      check($sformatf("reset_r%0d", a), got, 0);
    end
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("idle_no_done", dcount, 0);

    foreach (vecs[i]) begin
      do_issue(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb,
               vecs[i].ui, vecs[i].imm);
      read_reg(vecs[i].rd, got);
      check($sformatf("vec%0d_value", i), got, vecs[i].exp_val);
      check($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
    end

    // back-to-back with issue_valid held high
    @(negedge clk);
    idx = 0;
    budget = 0;
    issue_op = b2b[0].op; issue_rd = b2b[0].rd;
    issue_ra = b2b[0].ra; issue_rb = b2b[0].rb;
    issue_use_imm = b2b[0].ui; issue_imm = b2b[0].imm;
    issue_valid = 1'b1;
    while (idx < 3 && budget < 40) begin
      rdy = issue_ready;
      @(posedge clk);
      #1;
      budget++;
      if (rdy) begin
        acc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          issue_op = b2b[idx].op; issue_rd = b2b[idx].rd;
          issue_ra = b2b[idx].ra; issue_rb = b2b[idx].rb;
          issue_use_imm = b2b[idx].ui; issue_imm = b2b[idx].imm;
        end else begin
          issue_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_accepted", idx, 3);
    if (idx == 3) begin
      check("b2b_gap01", acc[1] - acc[0], 4);
      check("b2b_gap12", acc[2] - acc[1], 4);
    end
    repeat (3) @(negedge clk);
    foreach (b2b[i]) begin
      logic [7:0] o;
      logic [4:0] f;
      {o, f} = alu_f(b2b[i].op, m_read(b2b[i].ra),
                     b2b[i].ui ? b2b[i].imm : m_read(b2b[i].rb));
      if (b2b[i].rd != 3'd0) m_regs[b2b[i].rd] = o;
      m_flags = f;
    end
    read_reg(3'd5, got);
    check("b2b_r5", got, 8'hF0);
    read_reg(3'd6, got);
    check("b2b_r6", got, 8'h0F);
    check("b2b_flags", flags, m_flags);

    // reset during EXEC drops the instruction
    @(negedge clk);
    check("rst_test_ready", issue_ready, 1);
    issue_op = OP_SUM; issue_rd = 3'd7; issue_ra = 3'd0;
    issue_rb = 3'd0; issue_use_imm = 1'b1; issue_imm = 8'h55;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_exec_done", done, 0);
    check("rst_exec_ready", issue_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    m_flags = 5'b0;
    @(negedge clk);
    check("rst_after_ready", issue_ready, 1);
    check("rst_after_flags", flags, 0);
    read_reg(3'd7, got);
    check("rst_after_r7", got, 0);
    read_reg(3'd5, got);
    check("rst_after_r5", got, 0);
    dcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("rst_no_done", dcount, 0);

    // random instructions against the model
    for (int n = 0; n < 40; n++) begin
      do_issue(4'($urandom_range(0, 7)), 3'($urandom),
               3'($urandom), 3'($urandom),
               1'($urandom), 8'($urandom));
    end
    for (int a = 0; a < 8; a++) begin
      read_reg(3'(a), got);
      check($sformatf("final_r%0d", a), got, m_read(3'(a)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Operand-fetch and write-back stage wrapped around the 8-bit `alu`: owns the 8×8-bit general register file and the flags register. Accepts one decoded ALU instruction per handshake and reads source operands (register or immediate). Drives the ALU's `a`/`b`/`op` inputs from registered operands, then captures `out` and the five flags into the register file and flags register. The ALU itself stays combinational and external; this block sits on both sides of it, feeding it and consuming its results.

## Interface
- `NREGS`, 8, number of general registers; power of two.
- `RA_W`, 3, register address width, equal to log2(`NREGS`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  decoded instruction present.
- `issue_ready`  out  1  stage can accept an instruction.
- `issue_op`  in  4  ALU function code; one of `OP_*` from `constants.v`; passed through undecoded.
- `issue_rd`  in  `RA_W`  destination register.
- `issue_ra`  in  `RA_W`  first source register (ALU `a`).
- `issue_rb`  in  `RA_W`  second source register (ALU `b`).
- `issue_use_imm`  in  1  1: ALU `b` = `issue_imm`; 0: ALU `b` = reg[`issue_rb`].
- `issue_imm`  in  8  immediate operand.
- `alu_a`, `alu_b`  out  8  registered operands to the ALU.
- `alu_op`  out  4  registered function code to the ALU.
- `alu_out`  in  8  ALU result.
- `alu_zero`, `alu_negative`, `alu_carry`, `alu_overflow`, `alu_parity`  in  1 each  ALU flags.
- `flags`  out  5  architectural flags `{Z,N,C,V,P}`, bit 4 = Z.
- `done`  out  1  one-cycle pulse; result is committed on the edge ending this cycle.
- `dbg_addr`  in  `RA_W`  debug read address.
- `dbg_data`  out  8  combinational reg[`dbg_addr`]; r0 reads 0.

## Operation
- The FSM has four states: IDLE → READ → EXEC → WRITE → IDLE.
- IDLE: `issue_ready`=1. If `issue_valid`, latch op, rd, ra, rb, use_imm and imm, then go to READ. Otherwise stay in IDLE.
- READ: load `alu_a`←reg[ra] and `alu_b`←(use_imm ? imm : reg[rb]). Load `alu_op`←op. Go to EXEC.
- EXEC: the ALU settles during this full cycle. At the edge ending EXEC, capture `alu_out` into the result register and the five flag inputs into a pending-flags register. Go to WRITE.
- WRITE: `done`=1. At the edge ending WRITE, write reg[rd]←result and `flags`←pending. Go to IDLE.
- Register r0 is hard-wired to zero. Writes to r0 are discarded, but `flags` still update.
- Source reads happen in READ, so ra==rd or rb==rd uses the pre-write value.
- `alu_a`, `alu_b` and `alu_op` hold their last values outside READ. `flags` changes only at the end of WRITE.
- `issue_*` inputs are sampled only at the accepting edge; changes afterwards are ignored.
- The carry flag is latched exactly as the ALU presents it. No per-op masking is done in this block.

## Timing
- Reset values: state=IDLE, `issue_ready`=1, `done`=0, `alu_a`=`alu_b`=0, `alu_op`=0, `flags`=0, and all registers 0.
- Reset mid-operation: on the edge where `rst`=1, any in-flight instruction is dropped. No `done` pulse and no register or flags write occur, and the next cycle is IDLE.
- Acceptance at edge E0 (`issue_valid` & `issue_ready`) gives the sequence READ, EXEC, WRITE in cycles 1–3. `done` is high in cycle 3, and the commit happens at edge E3.
- Results are visible on `dbg_data` and `flags` from cycle 4. `issue_ready` is high again from cycle 4.
- Throughput is one instruction per 4 cycles. `issue_ready` is 0 in READ, EXEC and WRITE.
- If `issue_valid` is held high continuously, back-to-back instructions are accepted at E0, E4, E8, and so on. Each uses the results of the previous one; no forwarding is needed.
- `issue_ready` and `done` are decoded from the state register and are glitch-free.

## Test plan
- Reset, then apply `rst`=0. Expect `issue_ready`=1, `flags`=0 and all `dbg_data`=0. Issue nothing for 10 cycles and check that `done` stays 0.
- Issue `OP_SUM` with rd=1, ra=0, imm=0x7F, then `OP_SUM` with rd=1, ra=1, imm=0x01. Expect r1=0x80, `flags`=`{Z0,N1,C0,V1,P1}`, and `done` exactly once per instruction, 3 cycles after acceptance.
- Load r2=0xFF and r3=0x01 via immediates. Issue `OP_SUM` with rd=4, ra=2, rb=3. Expect r4=0x00, Z=1, C=1, P=0.
- Issue `OP_SUB` with rd=0, ra=0, imm=0x01. Expect r0 to read 0, and `flags` N=1, Z=0, C=0, P=0 (ALU out 0xFF).
- Hold `issue_valid`=1 with 3 queued instructions: r5←0+0x0F, then r5←r5 `OP_LSL` 4, then r6←`OP_NOT` r5. Expect acceptances 4 cycles apart, r5=0xF0 and r6=0x0F.
- Assert `rst` during the EXEC of r7←0+0x55. Expect no `done`, r7=0, `flags`=0, and IDLE on the next cycle.
